// File: rtl/rca_result_monitor_pkg.sv
// Shared types for the ripple-carry adder result monitor: FSM states,
// default widths and the operand/result vector record.
package rca_tb_pkg;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_CNT_W = 16;

    typedef enum logic [1:0] {
        MON_IDLE = 2'd0,
        MON_RUN  = 2'd1,
        MON_DONE = 2'd2
    } mon_state_t;

    // One adder observation: result is {cout, sum}
    typedef struct packed {
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
        logic                 cin;
        logic [DEF_WIDTH:0]   result;
    } rca_vec_t;

endpackage

// File: rtl/rca_result_monitor_if.sv
// Vector bus from the adder under test into the monitor; the adder side
// drives it (master), the monitor samples it (slave).
interface rca_result_monitor_if
    import rca_tb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) ();

    logic             in_valid;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic [WIDTH-1:0] sum;
    logic             cout;

    modport master (
        output in_valid,
        output op_a,
        output op_b,
        output cin,
        output sum,
        output cout
    );

    modport slave (
        input in_valid,
        input op_a,
        input op_b,
        input cin,
        input sum,
        input cout
    );

endinterface

// File: rtl/rca_golden_cmp.sv
// Combinational golden model of the adder: full-width a + b + cin and a
// compare against the observed {cout, sum}.
module rca_golden_cmp
    import rca_tb_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [WIDTH:0]   got,
    output logic [WIDTH:0]   exp_sum,
    output logic             mismatch
);

    // Operands are zero-extended first so the carry-out bit is never lost
    always_comb begin
        exp_sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        mismatch = (exp_sum != got);
    end

endmodule

// File: rtl/rca_result_monitor.sv
// Two-stage capture/check monitor for the ripple-carry adder: registers each
// vector, checks it against a golden sum and accumulates counts and snapshot.
module rca_result_monitor
    import rca_tb_pkg::*;
#(
    parameter int WIDTH      = DEF_WIDTH,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int TEST_LIMIT = 256
) (
    input  logic                 MAX10_CLK1_50,
    input  logic                 reset,
    input  logic                 start,
    rca_result_monitor_if.slave  vec,
    output logic                 busy,
    output logic                 done,
    output logic                 any_error,
    output logic [CNT_W-1:0]     test_count,
    output logic [CNT_W-1:0]     err_count,
    output logic [WIDTH-1:0]     first_a,
    output logic [WIDTH-1:0]     first_b,
    output logic [WIDTH:0]       first_got,
    output logic [WIDTH:0]       first_exp
);

    localparam logic [CNT_W-1:0] LIMIT    = CNT_W'(TEST_LIMIT);
    localparam logic [CNT_W-1:0] LIMIT_M1 = CNT_W'(TEST_LIMIT - 1);

    mon_state_t state;
    mon_state_t state_next;

    logic             accept;
    logic             run_entry;
    logic [CNT_W-1:0] acc_cnt;

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    logic             s1_cin;
    logic [WIDTH:0]   s1_got;

    logic             s2_valid;
    logic [WIDTH-1:0] s2_a;
    logic [WIDTH-1:0] s2_b;
    logic [WIDTH:0]   s2_got;
    logic [WIDTH:0]   s2_exp;
    logic             s2_mismatch;

    logic [WIDTH:0]   cmp_exp;
    logic             cmp_mismatch;

    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset) begin
            state <= MON_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The limit check uses the pre-increment count, so DONE is entered on the
    // same edge that accepts the final vector.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        run_entry  = 1'b0;
        case (state)
            MON_IDLE, MON_DONE: begin
                if (start) begin
                    state_next = MON_RUN;
                    run_entry  = 1'b1;
                end
            end
            MON_RUN: begin
                if (vec.in_valid && (acc_cnt < LIMIT)) begin
                    accept = 1'b1;
                    if (acc_cnt == LIMIT_M1) begin
                        state_next = MON_DONE;
                    end
                end
            end
            default: begin
                state_next = MON_IDLE;
            end
        endcase
    end

    assign busy = (state == MON_RUN);
    assign done = (state == MON_DONE);

    rca_golden_cmp #(
        .WIDTH (WIDTH)
    ) u_cmp (
        .a        (s1_a),
        .b        (s1_b),
        .cin      (s1_cin),
        .got      (s1_got),
        .exp_sum  (cmp_exp),
        .mismatch (cmp_mismatch)
    );

    // A run start wipes the same state as reset, so in-flight vectors from
    // the previous run never leak into the new counts.
    always_ff @(posedge MAX10_CLK1_50) begin
        if (reset || run_entry) begin
            acc_cnt     <= '0;
            s1_valid    <= 1'b0;
            s1_a        <= '0;
            s1_b        <= '0;
            s1_cin      <= 1'b0;
            s1_got      <= '0;
            s2_valid    <= 1'b0;
            s2_a        <= '0;
            s2_b        <= '0;
            s2_got      <= '0;
            s2_exp      <= '0;
            s2_mismatch <= 1'b0;
            any_error   <= 1'b0;
            test_count  <= '0;
            err_count   <= '0;
            first_a     <= '0;
            first_b     <= '0;
            first_got   <= '0;
            first_exp   <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_a    <= vec.op_a;
                s1_b    <= vec.op_b;
                s1_cin  <= vec.cin;
                s1_got  <= {vec.cout, vec.sum};
                acc_cnt <= acc_cnt + 1'b1;
            end

            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_a        <= s1_a;
                s2_b        <= s1_b;
                s2_got      <= s1_got;
                s2_exp      <= cmp_exp;
                s2_mismatch <= cmp_mismatch;
            end

            if (s2_valid) begin
                test_count <= test_count + 1'b1;
                if (s2_mismatch) begin
                    if (err_count != {CNT_W{1'b1}}) begin
                        err_count <= err_count + 1'b1;
                    end
                    any_error <= 1'b1;
                    if (!any_error) begin
                        first_a   <= s2_a;
                        first_b   <= s2_b;
                        first_got <= s2_got;
                        first_exp <= s2_exp;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_rca_result_monitor.sv
// Directed bench for rca_result_monitor: four instances with different
// limits/counter widths, driven one scenario at a time.
module tb_rca_result_monitor;
    import rca_tb_pkg::*;

    typedef struct {
        rca_vec_t v;
        int       exp_tc;
        int       exp_ec;
        logic     exp_any;
    } row_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;
    logic start_a, start_b, start_c, start_d;

    rca_result_monitor_if #(.WIDTH(8)) vif_a ();
    rca_result_monitor_if #(.WIDTH(8)) vif_b ();
    rca_result_monitor_if #(.WIDTH(8)) vif_c ();
    rca_result_monitor_if #(.WIDTH(8)) vif_d ();

    logic        busy_a, done_a, any_a;
    logic [15:0] tc_a, ec_a;
    logic [7:0]  fa_a, fb_a;
    logic [8:0]  fg_a, fe_a;

    logic        busy_b, done_b, any_b;
    logic [15:0] tc_b, ec_b;
    logic [7:0]  fa_b, fb_b;
    logic [8:0]  fg_b, fe_b;

    logic        busy_c, done_c, any_c;
    logic [3:0]  tc_c, ec_c;
    logic [7:0]  fa_c, fb_c;
    logic [8:0]  fg_c, fe_c;

    logic        busy_d, done_d, any_d;
    logic [15:0] tc_d, ec_d;
    logic [7:0]  fa_d, fb_d;
    logic [8:0]  fg_d, fe_d;

    int checks = 0;
    int errors = 0;

    rca_result_monitor #(.WIDTH(8), .CNT_W(16), .TEST_LIMIT(256)) dut_a (
        .MAX10_CLK1_50 (clk), .reset (reset), .start (start_a), .vec (vif_a),
        .busy (busy_a), .done (done_a), .any_error (any_a),
        .test_count (tc_a), .err_count (ec_a),
        .first_a (fa_a), .first_b (fb_a), .first_got (fg_a), .first_exp (fe_a)
    );

    rca_result_monitor #(.WIDTH(8), .CNT_W(16), .TEST_LIMIT(8)) dut_b (
        .MAX10_CLK1_50 (clk), .reset (reset), .start (start_b), .vec (vif_b),
        .busy (busy_b), .done (done_b), .any_error (any_b),
        .test_count (tc_b), .err_count (ec_b),
        .first_a (fa_b), .first_b (fb_b), .first_got (fg_b), .first_exp (fe_b)
    );

    rca_result_monitor #(.WIDTH(8), .CNT_W(4), .TEST_LIMIT(15)) dut_c (
        .MAX10_CLK1_50 (clk), .reset (reset), .start (start_c), .vec (vif_c),
        .busy (busy_c), .done (done_c), .any_error (any_c),
        .test_count (tc_c), .err_count (ec_c),
        .first_a (fa_c), .first_b (fb_c), .first_got (fg_c), .first_exp (fe_c)
    );

    rca_result_monitor #(.WIDTH(8), .TEST_LIMIT(1000)) dut_d (
        .MAX10_CLK1_50 (clk), .reset (reset), .start (start_d), .vec (vif_d),
        .busy (busy_d), .done (done_d), .any_error (any_d),
        .test_count (tc_d), .err_count (ec_d),
        .first_a (fa_d), .first_b (fb_d), .first_got (fg_d), .first_exp (fe_d)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input int which, input logic valid,
                                 input logic [7:0] a, input logic [7:0] b,
                                 input logic c, input logic [8:0] got);
        case (which)
            0: begin vif_a.in_valid = valid; vif_a.op_a = a; vif_a.op_b = b;
                     vif_a.cin = c; {vif_a.cout, vif_a.sum} = got; end
            1: begin vif_b.in_valid = valid; vif_b.op_a = a; vif_b.op_b = b;
                     vif_b.cin = c; {vif_b.cout, vif_b.sum} = got; end
            2: begin vif_c.in_valid = valid; vif_c.op_a = a; vif_c.op_b = b;
                     vif_c.cin = c; {vif_c.cout, vif_c.sum} = got; end
            default: begin vif_d.in_valid = valid; vif_d.op_a = a; vif_d.op_b = b;
                     vif_d.cin = c; {vif_d.cout, vif_d.sum} = got; end
        endcase
    endtask

    function automatic row_t mkRow(input logic [7:0] a, input logic [7:0] b,
                                   input logic c, input logic [8:0] res,
                                   input int tc, input int ec, input logic any);
        row_t r;
        r.v.a = a; r.v.b = b; r.v.cin = c; r.v.result = res;
        r.exp_tc = tc; r.exp_ec = ec; r.exp_any = any;
        return r;
    endfunction

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired actual=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        row_t       rows[6];
        logic [7:0] ra, rb;
        logic       rc;
        logic [8:0] rg;
        int         accepted;
        int         cyc;
        logic       v;

        // Expected {cout,sum} values worked out by hand
        rows[0] = mkRow(8'h0F, 8'h01, 1'b0, 9'h010, 1, 0, 1'b0);
        rows[1] = mkRow(8'h80, 8'h7F, 1'b1, 9'h100, 2, 0, 1'b0);
        rows[2] = mkRow(8'hFF, 8'hFF, 1'b1, 9'h1FF, 3, 0, 1'b0);
        rows[3] = mkRow(8'h00, 8'h00, 1'b0, 9'h000, 4, 0, 1'b0);
        rows[4] = mkRow(8'hFF, 8'h01, 1'b1, 9'h000, 5, 1, 1'b1);
        rows[5] = mkRow(8'h12, 8'h34, 1'b0, 9'h047, 6, 2, 1'b1);

        reset = 1'b1;
        start_a = 1'b0; start_b = 1'b0; start_c = 1'b0; start_d = 1'b0;
        for (int k = 0; k < 4; k++) applyStimulus(k, 1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
        repeat (3) @(negedge clk);

        checkOutput("rst_busy", busy_a, 0);
        checkOutput("rst_done", done_a, 0);
        checkOutput("rst_any", any_a, 0);
        checkOutput("rst_tc", tc_a, 0);
        checkOutput("rst_ec", ec_a, 0);
        checkOutput("rst_snap", {fa_a, fb_a, fg_a, fe_a}, 0);
        reset = 1'b0;

        // start with a (bad) vector on the same edge: must be dropped
        @(negedge clk);
        start_a = 1'b1;
        applyStimulus(0, 1'b1, 8'h33, 8'h44, 1'b0, 9'h000);
        @(negedge clk);
        start_a = 1'b0;
        applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
        checkOutput("a_busy_after_start", busy_a, 1);
        repeat (3) @(negedge clk);
        checkOutput("a_start_vec_dropped_tc", tc_a, 0);
        checkOutput("a_start_vec_dropped_ec", ec_a, 0);

        for (int i = 0; i < 6; i++) begin
            applyStimulus(0, 1'b1, rows[i].v.a, rows[i].v.b, rows[i].v.cin, rows[i].v.result);
            @(negedge clk);
            applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
            @(negedge clk);
            checkOutput($sformatf("a_row%0d_tc_early", i), tc_a, rows[i].exp_tc - 1);
            @(negedge clk);
            checkOutput($sformatf("a_row%0d_tc", i), tc_a, rows[i].exp_tc);
            checkOutput($sformatf("a_row%0d_ec", i), ec_a, rows[i].exp_ec);
            checkOutput($sformatf("a_row%0d_any", i), any_a, rows[i].exp_any);
        end
        checkOutput("a_first_a", fa_a, 8'hFF);
        checkOutput("a_first_b", fb_a, 8'h01);
        checkOutput("a_first_exp", fe_a, 9'h101);
        checkOutput("a_first_got", fg_a, 9'h000);
        checkOutput("a_still_busy", busy_a, 1);

        // reset with two bad vectors in flight
        applyStimulus(0, 1'b1, 8'h01, 8'h01, 1'b0, 9'h005);
        @(negedge clk);
        applyStimulus(0, 1'b1, 8'h02, 8'h02, 1'b0, 9'h009);
        @(negedge clk);
        applyStimulus(0, 1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("mrst_busy", busy_a, 0);
        checkOutput("mrst_done", done_a, 0);
        checkOutput("mrst_any", any_a, 0);
        checkOutput("mrst_counts", {tc_a, ec_a}, 0);
        checkOutput("mrst_snap", {fa_a, fb_a, fg_a, fe_a}, 0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("mrst_drain_tc", tc_a, 0);
        checkOutput("mrst_drain_ec", ec_a, 0);

        // TEST_LIMIT=8, in_valid held for 20 cycles
        start_b = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start_b = 1'b0;
            if (i == 7) checkOutput("b_done_before_limit", done_b, 0);
            if (i == 8) begin
                checkOutput("b_done_at_limit", done_b, 1);
                checkOutput("b_tc_at_done", tc_b, 6);
            end
            ra = 8'(i * 17);
            rb = 8'(i * 3);
            rc = 1'(i);
            rg = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            applyStimulus(1, 1'b1, ra, rb, rc, rg);
        end
        @(negedge clk);
        applyStimulus(1, 1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
        repeat (3) @(negedge clk);
        checkOutput("b_tc", tc_b, 8);
        checkOutput("b_ec", ec_b, 0);
        checkOutput("b_done", done_b, 1);
        checkOutput("b_busy", busy_b, 0);

        // CNT_W=4, TEST_LIMIT=15, every vector bad (got = correct + 1)
        @(negedge clk);
        start_c = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            start_c = 1'b0;
            ra = 8'(i + 1);
            rg = {1'b0, ra} + 9'd2 + 9'd1;
            applyStimulus(2, 1'b1, ra, 8'h02, 1'b0, rg);
        end
        @(negedge clk);
        applyStimulus(2, 1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
        repeat (3) @(negedge clk);
        checkOutput("c_tc", tc_c, 15);
        checkOutput("c_ec", ec_c, 15);
        checkOutput("c_any", any_c, 1);
        checkOutput("c_done", done_c, 1);
        checkOutput("c_first_a", fa_c, 8'h01);
        checkOutput("c_first_b", fb_c, 8'h02);
        checkOutput("c_first_exp", fe_c, 9'h003);
        checkOutput("c_first_got", fg_c, 9'h004);
        repeat (5) @(negedge clk);
        checkOutput("c_ec_holds", ec_c, 15);
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        checkOutput("c_restart_tc", tc_c, 0);
        checkOutput("c_restart_ec", ec_c, 0);
        checkOutput("c_restart_any", any_c, 0);
        checkOutput("c_restart_snap", {fa_c, fb_c, fg_c, fe_c}, 0);
        checkOutput("c_restart_busy", busy_c, 1);
        checkOutput("c_restart_done", done_c, 0);

        // 1000 random correct vectors with random gaps
        @(negedge clk);
        start_d = 1'b1;
        @(negedge clk);
        start_d = 1'b0;
        accepted = 0;
        cyc = 0;
        while (accepted < 1000 && cyc < 5000) begin
            v  = ($urandom_range(0, 3) != 0);
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            rc = 1'($urandom_range(0, 1));
            rg = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            applyStimulus(3, v, ra, rb, rc, rg);
            @(negedge clk);
            if (v) accepted++;
            cyc++;
        end
        applyStimulus(3, 1'b0, 8'h00, 8'h00, 1'b0, 9'h000);
        checkOutput("d_accepted_in_budget", accepted, 1000);
        repeat (3) @(negedge clk);
        checkOutput("d_tc", tc_d, 1000);
        checkOutput("d_ec", ec_d, 0);
        checkOutput("d_any", any_d, 0);
        checkOutput("d_done", done_d, 1);
        checkOutput("d_busy", busy_d, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rca_result_monitor.md
# rca_result_monitor

Self-checking capture stage directly downstream of the ripple-carry adder under timing analysis. Each cycle it registers the adder's operands and result, compares the result against a golden `a + b + cin`, and accumulates test and mismatch counts plus a snapshot of the first failing vector. Counts and snapshot feed the board's HEX display logic; the adder's launch registers and this block's capture registers form the measured timing path.

## Interface
Parameters:
- `WIDTH`, 8, operand/sum width.
- `CNT_W`, 16, width of test/error counters.
- `TEST_LIMIT`, 256, number of vectors accepted per run (1..2^CNT_W-1).

Ports:
- Clock `MAX10_CLK1_50`; reset `reset`. Synchronous, active-high; the top level drives `reset` as the inverse of `KEY[0]`.
- `start`  in  1  begin a run: clear counters/snapshot, enter RUN.
- `in_valid`  in  1  operands/result on this cycle form a vector.
- `op_a`, `op_b`  in  WIDTH  adder operands.
- `cin`  in  1  adder carry-in.
- `sum`  in  WIDTH  adder sum output.
- `cout`  in  1  adder carry-out.
- `busy`  out  1  FSM in RUN.
- `done`  out  1  FSM in DONE.
- `any_error`  out  1  sticky: at least one mismatch this run.
- `test_count`  out  CNT_W  vectors checked.
- `err_count`  out  CNT_W  mismatches, saturating.
- `first_a`, `first_b`  out  WIDTH  operands of first mismatch.
- `first_got`, `first_exp`  out  WIDTH+1  `{cout,sum}` observed / expected at first mismatch.

## Operation
- FSM states IDLE, RUN, DONE. Reset → IDLE. IDLE --start--> RUN. RUN --(accepted == TEST_LIMIT)--> DONE. DONE --start--> RUN. `start` in RUN is ignored.
- Entering RUN (the edge on which `start` is sampled) clears `test_count`, `err_count`, `any_error`, the snapshot, the internal accept counter and both pipeline valid bits.
- Stage 1 (capture): on an edge in RUN with `in_valid=1` and accept counter < TEST_LIMIT, register `op_a`, `op_b`, `cin`, `{cout,sum}`; set s1_valid; increment accept counter. Otherwise s1_valid=0.
- Stage 2 (check): compute `exp = op_a + op_b + cin` at WIDTH+1 bits (zero-extended, no truncation); `mismatch = (exp != got)`. Register exp, got, operands, mismatch, s2_valid.
- Update: when s2_valid, `test_count++`; if mismatch, `err_count` increments unless all-ones (saturates), `any_error`←1, and the snapshot loads only if `any_error` was 0.
- Vectors already in the pipeline when the limit is reached still complete; exactly TEST_LIMIT vectors are counted per run.
- `in_valid` in IDLE/DONE or on the `start` edge is dropped.

## Timing
- Reset values: `busy=0`, `done=0`, `any_error=0`, counters 0, snapshot 0, pipeline invalid.
- Latency: vector sampled at edge N → counters/snapshot visible after edge N+2.
- `busy` goes high the cycle after `start` is sampled.
- The FSM enters DONE on the edge that accepts the TEST_LIMIT-th vector. `done` is asserted while the last two vectors drain, and final counts are stable 2 cycles after `done` rises.
- Full-throughput: one vector per cycle, no back-pressure.
- Reset mid-run: all state is cleared on that edge and in-flight vectors are discarded.

## Structure
- Shared package `rca_tb_pkg`: FSM state enum (`MON_IDLE`, `MON_RUN`, `MON_DONE`), default WIDTH/CNT_W constants, and a vector struct {a, b, cin, result}.
- One sub-module, `rca_golden_cmp`: combinational WIDTH+1 expected-sum and compare. It contains no state and is reused by the stage-2 register.

## Test plan
- Reset, then `start`, then 4 correct vectors (e.g. 0x0F+0x01+0 → got 0x010) → `test_count=4`, `err_count=0`, `any_error=0`, after edge N+2 of the last vector.
- Mismatch injection: a=0xFF, b=0x01, cin=1, got=0x000 (expected 0x101), followed by a second bad vector → `err_count=2`, snapshot holds the first vector (`first_exp=0x101`, `first_got=0x000`).
- TEST_LIMIT=8 with `in_valid` held high for 20 cycles → `test_count=8`, `done=1`, `busy=0`; further vectors are ignored.
- Saturation with CNT_W=4, TEST_LIMIT=15, all vectors bad; bench also drives `start` again during DONE → `err_count=15` holds and does not wrap; the restart clears all counters to 0.
- `start` together with `in_valid` in IDLE → that vector is not counted. `reset` asserted with 2 vectors in flight → all outputs 0 and FSM in IDLE on the next cycle.
- Random 1000 vectors against a reference model with `CNT_W` defaulting, using TEST_LIMIT=1000 and sum forced correct → `err_count=0`, `test_count=1000`.
